ks16_add_sched: RTL and testbench

Round-robin scheduler that shares one pipelined 16-bit Kogge-Stone adder among N_REQ requesters, typically the butterfly add/sub ports of the FFT datapath. It does the following:
- accepts operand pairs over valid/ready handshakes;
- maps subtract to inverted-B plus carry-in;
- drives the adder's pipeline enable;
- carries requester tag and overflow sideband alongside the adder's stages;
- returns each result on one shared response port with backpressure.

---
 rtl/ks16_add_sched.sv | 192 +++++++++++++++++++
 tb/tb_ks16_add_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks16_add_sched.sv
// ks16_add_sched
// -----------------------------------------------------------------------------
// Round-robin scheduler that shares one external pipelined 16-bit adder
// (LAT register stages, operand to sum) among N_REQ requesters.
// A subtract is issued as A + ~B + 1. The requester tag and the two operand
// sign bits travel down a sideband shift register that mirrors the adder
// pipeline. The sign bits let the signed overflow be judged when the sum
// emerges. Results land in a single output register with valid/ready
// backpressure. While that register is stalled, the adder, the sideband and
// the arbiter all freeze.
//
// Optional feature (macro KS16_SAT_EN):
//   defined   : o_rsp_sum saturates to 16'h7FFF / 16'h8000 on signed overflow
//   undefined : o_rsp_sum is the raw two's-complement adder sum
//
// Ports
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_req_vld/o_req_rdy  per-requester handshake (o_req_rdy one-hot or zero)
//   i_req_a/i_req_b      packed signed operands, requester k at [16k+15:16k]
//   i_req_sub            1 = A-B, 0 = A+B
//   o_add_vld/a/b/c0     issue slot to the external adder
//   o_add_en             adder pipeline register enable
//   i_add_sum/i_add_cout adder result, LAT enabled cycles after issue
//   o_rsp_*              result port: valid, sum, cout, overflow, tag
//   i_rsp_rdy            consumer accepts the result
//   o_busy               any op in flight or held in the output register
// -----------------------------------------------------------------------------
module ks16_add_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req_vld,
    output logic [N_REQ-1:0]           o_req_rdy,
    input  logic [16*N_REQ-1:0]        i_req_a,
    input  logic [16*N_REQ-1:0]        i_req_b,
    input  logic [N_REQ-1:0]           i_req_sub,
    output logic                       o_add_vld,
    output logic [15:0]                o_add_a,
    output logic [15:0]                o_add_b,
    output logic                       o_add_c0,
    output logic                       o_add_en,
    input  logic [15:0]                i_add_sum,
    input  logic                       i_add_cout,
    output logic                       o_rsp_vld,
    input  logic                       i_rsp_rdy,
    output logic [15:0]                o_rsp_sum,
    output logic                       o_rsp_cout,
    output logic                       o_rsp_ovf,
    output logic [$clog2(N_REQ)-1:0]   o_rsp_tag,
    output logic                       o_busy
);

    localparam int TAG_W = $clog2(N_REQ);

    // Signed overflow of a + b' (+c0): operands agree in sign, result does not.
    function automatic logic ovf_chk(input logic a15, input logic b15, input logic s15);
        return (a15 == b15) && (s15 != a15);
    endfunction

`ifdef KS16_SAT_EN
    // Clamp toward the sign of A, which is the sign of the true result on overflow.
    function automatic logic signed [15:0] sat16(input logic signed [15:0] s,
                                                 input logic ovf, input logic a15);
        if (!ovf)
            return s;
        return a15 ? 16'sh8000 : 16'sh7FFF;
    endfunction
`endif

    logic                   en;
    logic                   gnt_any;
    logic [TAG_W-1:0]       gnt_idx;
    logic [TAG_W-1:0]       cand;
    logic [TAG_W-1:0]       ptr;
    logic [N_REQ-1:0]       grant;
    logic [15:0]            a_arr [N_REQ];
    logic [15:0]            b_arr [N_REQ];

    // Sideband stage i is aligned with adder register stage i+1.
    logic [LAT-1:0]         vld_p;
    logic [TAG_W-1:0]       tag_p [LAT];
    logic                   a15_p [LAT];
    logic                   b15_p [LAT];

    logic                   ovf_out;
    logic signed [15:0]     sum_out;

    // A stalled output register freezes everything upstream of it.
    assign en       = !(o_rsp_vld && !i_rsp_rdy);
    assign o_add_en = en;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = i_req_a[16*g +: 16];
        assign b_arr[g] = i_req_b[16*g +: 16];
    end

    // ---- issue stage: round-robin arbitration and operand select ----
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        // No grant while in reset so o_req_rdy reads zero.
        if (en && i_rst_n) begin
            // Search starts just past the last winner.
            for (int i = 1; i <= N_REQ; i++) begin
                cand = TAG_W'((int'(ptr) + i) % N_REQ);
                if (!gnt_any && i_req_vld[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
            if (gnt_any)
                grant[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        o_add_a  = '0;
        o_add_b  = '0;
        o_add_c0 = 1'b0;
        if (gnt_any) begin
            o_add_a  = a_arr[gnt_idx];
            o_add_b  = i_req_sub[gnt_idx] ? ~b_arr[gnt_idx] : b_arr[gnt_idx];
            o_add_c0 = i_req_sub[gnt_idx];
        end
    end

    assign o_req_rdy = grant;
    assign o_add_vld = gnt_any;

    // ---- sideband stages p0 .. p(LAT-1): control ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p <= '0;
            ptr   <= TAG_W'(N_REQ - 1);
        end else if (en) begin
            vld_p[0] <= gnt_any;
            for (int i = 1; i < LAT; i++)
                vld_p[i] <= vld_p[i-1];
            if (gnt_any)
                ptr <= gnt_idx;
        end
    end

    // ---- sideband stages p0 .. p(LAT-1): data, qualified by vld_p ----
    always_ff @(posedge i_clk) begin
        if (en) begin
            tag_p[0] <= gnt_idx;
            a15_p[0] <= o_add_a[15];
            b15_p[0] <= o_add_b[15];
            for (int i = 1; i < LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
                a15_p[i] <= a15_p[i-1];
                b15_p[i] <= b15_p[i-1];
            end
        end
    end

    // ---- adder output meets last sideband stage ----
    assign ovf_out = ovf_chk(a15_p[LAT-1], b15_p[LAT-1], i_add_sum[15]);
`ifdef KS16_SAT_EN
    assign sum_out = sat16(i_add_sum, ovf_out, a15_p[LAT-1]);
`else
    assign sum_out = i_add_sum;
`endif

    // ---- output register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_vld  <= 1'b0;
            o_rsp_sum  <= '0;
            o_rsp_cout <= 1'b0;
            o_rsp_ovf  <= 1'b0;
            o_rsp_tag  <= '0;
        end else if (en && vld_p[LAT-1]) begin
            // Covers both an empty register and a same-cycle handshake + reload.
            o_rsp_vld  <= 1'b1;
            o_rsp_sum  <= sum_out;
            o_rsp_cout <= i_add_cout;
            o_rsp_ovf  <= ovf_out;
            o_rsp_tag  <= tag_p[LAT-1];
        end else if (o_rsp_vld && i_rsp_rdy) begin
            o_rsp_vld  <= 1'b0;
        end
    end

    assign o_busy = (|vld_p) | o_rsp_vld;

endmodule

// File: tb/tb_ks16_add_sched.sv
// Testbench for ks16_add_sched: behavioural model of the scheduler plus a
// model of the external LAT-stage adder, directed cases with literal
// expectations, and a randomized stream with backpressure and resets.
module tb_ks16_add_sched;

    localparam int N   = 4;
    localparam int LAT = 6;
    localparam int TW  = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      req_vld = '0;
    logic [N-1:0]      req_rdy;
    logic [16*N-1:0]   req_a = '0;
    logic [16*N-1:0]   req_b = '0;
    logic [N-1:0]      req_sub = '0;
    logic              add_vld;
    logic [15:0]       add_a, add_b;
    logic              add_c0, add_en;
    logic [15:0]       add_sum;
    logic              add_cout;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b1;
    logic [15:0]       rsp_sum;
    logic              rsp_cout, rsp_ovf;
    logic [TW-1:0]     rsp_tag;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    ks16_add_sched #(.N_REQ(N), .LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
        .o_add_vld(add_vld), .o_add_a(add_a), .o_add_b(add_b),
        .o_add_c0(add_c0), .o_add_en(add_en),
        .i_add_sum(add_sum), .i_add_cout(add_cout),
        .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy),
        .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_rsp_ovf(rsp_ovf),
        .o_rsp_tag(rsp_tag), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // External adder: LAT enabled register stages, no reset.
    logic [16:0] apipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        if (add_en) begin
            apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_c0};
            for (int i = 1; i < LAT; i++)
                apipe[i] <= apipe[i-1];
        end
    end
    assign add_sum  = apipe[LAT-1][15:0];
    assign add_cout = apipe[LAT-1][16];

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          tag;
        int          cnt;   // enabled edges still needed before it can be loaded
    } item_t;

    item_t q[$];
    item_t m_rsp;
    logic  m_rsp_vld = 1'b0;
    int    m_ptr = N - 1;

    function automatic item_t expect_op(int k, logic [15:0] a, logic [15:0] b, logic sub);
        item_t it;
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        it.ovf = (r > 32767) || (r < -32768);
        it.sum = r[15:0];
`ifdef KS16_SAT_EN
        if (it.ovf)
            it.sum = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        it.cout = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        it.tag  = k;
        it.cnt  = LAT - 1;
        return it;
    endfunction

    // Winner is the valid requester at the smallest circular distance past ptr.
    function automatic int mdl_grant(logic [N-1:0] vld, int ptr);
        int best, bestd, d;
        best = -1;
        bestd = N;
        for (int j = 0; j < N; j++) begin
            if (vld[j]) begin
                d = (j - ptr - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = j;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rsp_vld = 1'b0;
        m_ptr = N - 1;
    endtask

    task automatic model_step();
        int g;
        if (m_rsp_vld && !rsp_rdy)
            return;
        g = mdl_grant(req_vld, m_ptr);
        if (q.size() > 0 && q[0].cnt == 0) begin
            m_rsp = q.pop_front();
            m_rsp_vld = 1'b1;
        end else if (m_rsp_vld && rsp_rdy) begin
            m_rsp_vld = 1'b0;
        end
        foreach (q[i])
            q[i].cnt--;
        if (g >= 0) begin
            q.push_back(expect_op(g, req_a[16*g +: 16], req_b[16*g +: 16], req_sub[g]));
            m_ptr = g;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        int g;
        logic en;
        logic [N-1:0] eg;
        logic [15:0] eb;
        if (!rst_n)
            model_reset();
        en = !(m_rsp_vld && !rsp_rdy);
        g  = (en && rst_n) ? mdl_grant(req_vld, m_ptr) : -1;
        eg = '0;
        if (g >= 0)
            eg[g] = 1'b1;
        chk("req_rdy", req_rdy, eg);
        chk("add_en", add_en, en);
        chk("add_vld", add_vld, g >= 0);
        if (g >= 0) begin
            eb = req_sub[g] ? ~req_b[16*g +: 16] : req_b[16*g +: 16];
            chk("add_a", add_a, req_a[16*g +: 16]);
            chk("add_b", add_b, eb);
            chk("add_c0", add_c0, req_sub[g]);
        end else begin
            chk("add_a_idle", add_a, 0);
            chk("add_b_idle", add_b, 0);
            chk("add_c0_idle", add_c0, 0);
        end
        chk("rsp_vld", rsp_vld, m_rsp_vld);
        if (m_rsp_vld) begin
            chk("rsp_sum", rsp_sum, m_rsp.sum);
            chk("rsp_cout", rsp_cout, m_rsp.cout);
            chk("rsp_ovf", rsp_ovf, m_rsp.ovf);
            chk("rsp_tag", rsp_tag, m_rsp.tag);
        end
        chk("busy", busy, (q.size() != 0) || m_rsp_vld);
    endtask

    // ---------------- directed stimulus ----------------
    task automatic dir_op(string nm, int k, logic [15:0] a, logic [15:0] b, logic sub,
                          logic [15:0] eb, logic [15:0] esum, logic eovf, logic ecout);
        int n;
        logic [N-1:0] eg;
        @(posedge clk); #1;
        req_vld = '0;
        req_vld[k] = 1'b1;
        req_a[16*k +: 16] = a;
        req_b[16*k +: 16] = b;
        req_sub = '0;
        req_sub[k] = sub;
        rsp_rdy = 1'b1;
        #1;
        eg = '0;
        eg[k] = 1'b1;
        chk({nm, "_grant"}, req_rdy, eg);
        chk({nm, "_add_b"}, add_b, eb);
        chk({nm, "_c0"}, add_c0, sub);
        @(posedge clk); #1;
        req_vld = '0;
        n = 0;
        while (!rsp_vld && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        // Handshake edge plus LAT further edges: LAT+1 cycles from request.
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_sum"}, rsp_sum, esum);
        chk({nm, "_ovf"}, rsp_ovf, eovf);
        chk({nm, "_cout"}, rsp_cout, ecout);
        chk({nm, "_tag"}, rsp_tag, k);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_vld = '1;
        #1;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_add_en", add_en, 1);
        chk("rst_add_vld", add_vld, 0);
        repeat (2) @(posedge clk);
        #1;
        req_vld = '0;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            req_a[16*k +: 16] = rand_opnd();
            req_b[16*k +: 16] = rand_opnd();
        end
        req_sub = N'($urandom);
    endtask

    task automatic rr_test();
        int cnt;
        logic [N-1:0] eg;
        do_reset();
        rsp_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12 + LAT + 6; i++) begin
            req_vld = (i < 12) ? '1 : '0;
            rand_ops();
            #1;
            if (i < 12) begin
                eg = N'(1) << (i % N);
                chk("rr_grant", req_rdy, eg);
            end
            if (rsp_vld) begin
                chk("rr_tag", rsp_tag, cnt % N);
                cnt++;
            end
            @(posedge clk); #1;
        end
        chk("rr_count", cnt, 12);
    endtask

    task automatic bp_test();
        int issued, got, hold, cyc;
        logic held_done, hs, rhs;
        logic [15:0] s_sum;
        logic s_ovf, s_cout;
        logic [TW-1:0] s_tag;
        issued = 0; got = 0; hold = 0; cyc = 0;
        held_done = 1'b0; hs = 1'b0; rhs = 1'b0;
        s_sum = '0; s_ovf = 1'b0; s_cout = 1'b0; s_tag = '0;
        @(posedge clk);
        forever begin
            if (hs) issued++;
            if (rhs) got++;
            if (got >= 8 || cyc >= 80) break;
            #1;
            req_vld = (issued < 8) ? '1 : '0;
            rand_ops();
            if (!held_done && rsp_vld) begin
                hold = 5;
                held_done = 1'b1;
                s_sum = rsp_sum; s_ovf = rsp_ovf; s_cout = rsp_cout; s_tag = rsp_tag;
            end
            rsp_rdy = (hold == 0);
            #1;
            hs  = |req_rdy;
            rhs = rsp_vld && rsp_rdy;
            if (hold > 0) begin
                chk("bp_add_en", add_en, 0);
                chk("bp_req_rdy", req_rdy, 0);
                chk("bp_rsp_vld", rsp_vld, 1);
                chk("bp_sum_stable", rsp_sum, s_sum);
                chk("bp_ovf_stable", rsp_ovf, s_ovf);
                chk("bp_cout_stable", rsp_cout, s_cout);
                chk("bp_tag_stable", rsp_tag, s_tag);
                hold--;
            end
            @(posedge clk);
            cyc++;
        end
        #1;
        req_vld = '0;
        rsp_rdy = 1'b1;
        chk("bp_results", got, 8);
        chk("bp_issued", issued, 8);
        chk("bp_hold_seen", held_done, 1);
    endtask

    task automatic rst_flight_test();
        int cnt;
        @(posedge clk); #1;
        req_vld = '1;
        rsp_rdy = 1'b1;
        rand_ops();
        repeat (3) @(posedge clk);
        #1;
        req_vld = '0;
        chk("rf_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rf_rsp_vld", rsp_vld, 0);
        chk("rf_busy", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_vld = '1;
        #1;
        chk("rf_first_grant", req_rdy, 1);
        @(posedge clk); #1;
        req_vld = '0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_vld) begin
                chk("rf_tag", rsp_tag, 0);
                cnt++;
            end
            @(posedge clk); #1;
        end
        chk("rf_rsp_count", cnt, 1);
    endtask

    task automatic rand_test();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            rst_n   = !(cyc % 500 == 250);
            req_vld = N'($urandom);
            rand_ops();
            rsp_rdy = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_vld = '0;
        rsp_rdy = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("drain_busy", busy, 0);
    endtask

    task automatic run_tests();
        repeat (3) @(posedge clk);
        #1;
        req_vld = '0;
        rst_n = 1'b1;
        dir_op("add", 0, 16'h1234, 16'h0101, 1'b0, 16'h0101, 16'h1335, 1'b0, 1'b0);
        dir_op("sub", 2, 16'h0005, 16'h0007, 1'b1, 16'hFFF8, 16'hFFFE, 1'b0, 1'b0);
`ifdef KS16_SAT_EN
        dir_op("ovf_pos", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
        dir_op("ovf_neg", 3, 16'h8000, 16'h0001, 1'b1, 16'hFFFE, 16'h8000, 1'b1, 1'b1);
`else
        dir_op("ovf_pos", 1, 16'h7FFF, 16'h0001, 1'b0, 16'h0001, 16'h8000, 1'b1, 1'b0);
        dir_op("ovf_neg", 3, 16'h8000, 16'h0001, 1'b1, 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
`endif
        dir_op("wrap_carry", 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1);
        rr_test();
        bp_test();
        rst_flight_test();
        rand_test();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        req_vld = '1;
        fork
            forever begin
                @(negedge clk);
                check_cycle();
                @(posedge clk or negedge rst_n);
                if (!rst_n)
                    model_reset();
                else
                    model_step();
            end
            begin
                run_tests();
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        join
    end

endmodule
